imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  - Upstream of the single-cycle core: streams a program image, byte by byte, into the instruction memory write port.
//  - Holds the core in reset until the image is complete, then releases it so fetch starts at PC 0.
//  - Sits between a byte source (UART RX or test host) and the core/instruction memory pair.
// PARAMETERS
//  ADDR_WIDTH  8  instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH words
// PORTS
//  clk_i          in   1           single clock; all logic on rising edge
//  reset_i        in   1           reset: synchronous, active-low
//  start_i        in   1           arm a load (single-cycle pulse)
//  byte_valid_i   in   1           source has a byte
//  byte_data_i    in   8           byte payload
//  byte_ready_o   out  1           loader accepts a byte; transfer occurs when valid && ready
//  imem_we_o      out  1           instruction-memory write strobe (one cycle per word)
//  imem_addr_o    out  ADDR_WIDTH  word address of write
//  imem_wdata_o   out  32          instruction word
//  core_reset_no  out  1           core reset, active-low; 0 = core held
//  busy_o         out  1           load in progress
//  done_o         out  1           image loaded, core released
//  error_o        out  1           image rejected
//  word_count_o   out  ADDR_WIDTH+1  words written in current load
// BEHAVIOUR
//  - Reset (reset_i == 0 at an edge): state is IDLE.
//    - All outputs are 0: byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_no, busy_o, done_o, error_o, word_count_o.
//    - Internal byte index and header are cleared.
//    - Reset mid-load aborts the load; words already written stay in memory.
//  - Image format, all words little-endian (first byte = bits [7:0]):
//    - header word N (word count);
//    - then N instruction words;
//    - then a checksum word, only when BOOT_CHECKSUM_EN is defined.
//  - States: IDLE, HDR, LOAD, CHK, DONE, ERR.
//  - byte_ready_o = 1 only in HDR, LOAD and CHK. busy_o = 1 in those three states.
//  - IDLE:
//    - start_i -> HDR; clear word_count_o, byte index, done_o, error_o.
//  - HDR: after the 4th byte is accepted, N is latched.
//    - N == 0 -> DONE.
//    - N > MAX_WORDS -> ERR.
//    - otherwise -> LOAD.
//  - LOAD: bytes are assembled using a 2-bit byte index that wraps 3 -> 0.
//    - On the edge that accepts the 4th byte: imem_we_o = 1 for exactly one cycle.
//      - It is registered, so it is high in the cycle after the accepting edge.
//      - imem_addr_o = word_count_o (pre-increment); imem_wdata_o = assembled word.
//    - word_count_o increments on the same edge.
//    - When the incremented count == N -> DONE (or CHK with BOOT_CHECKSUM_EN).
//    - Back-to-back bytes with no bubbles are legal: max rate is 1 word per 4 cycles.
//  - DONE:
//    - core_reset_no = 1 and done_o = 1 from the first DONE cycle.
//    - Held until start_i or reset.
//  - ERR:
//    - error_o = 1; core_reset_no stays 0.
//    - Held until start_i or reset.
//  - start_i:
//    - In DONE or ERR -> HDR. core_reset_no drops to 0 on the same edge; done_o/error_o clear.
//    - Ignored in HDR, LOAD and CHK.
//  - Simultaneous reset and start_i: reset wins.
//  - imem_addr_o and imem_wdata_o hold their last values when imem_we_o = 0.
//  - N == MAX_WORDS is legal. The last address written is MAX_WORDS-1; word_count_o reaches MAX_WORDS with no wrap.
// CONFIGURATION
//  - BOOT_CHECKSUM_EN defined:
//    - Keep a running 32-bit modulo sum of all N instruction words; header excluded.
//    - CHK accepts 4 bytes. Equal to the sum -> DONE; otherwise -> ERR.
//    - N == 0 still passes through CHK, with expected sum 0.
//  - BOOT_CHECKSUM_EN undefined:
//    - No CHK state and no sum register.
//    - LOAD goes directly to DONE after word N.
// TESTING
//  - Reset, then start_i, then header 2, then words 0x00500093 and 0x00A00113:
//    - imem_we_o pulses at addr 0 and addr 1 with those data;
//    - done_o = 1, core_reset_no = 1, word_count_o = 2.
//  - Header N = 0:
//    - no imem_we_o pulse;
//    - DONE in the cycle after the 4th header byte (checksum build: after checksum 0).
//  - Header N = MAX_WORDS + 1 (257 at default):
//    - error_o = 1; core_reset_no stays 0; no write occurs.
//  - Assert reset after 6 payload bytes:
//    - next cycle all outputs are 0 and state is IDLE;
//    - a following start_i with a full 1-word image completes normally.
//  - Interleave byte_valid_i gaps randomly during a 3-word load:
//    - identical addresses and data to the gap-free run;
//    - start_i asserted mid-LOAD has no effect.
//  - BOOT_CHECKSUM_EN: words 0x1 and 0x2:
//    - trailer 0x3 -> done_o = 1;
//    - trailer 0x4 -> error_o = 1 and core_reset_no = 0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a byte image (header N, N words, optional checksum) into imem, then releases the core.
// Optional checksum trailer enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  core_reset_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, DONE, ERR} state_t;
  localparam state_t FIN = CHK;
  logic [31:0] sum_q, sum_d;
`else
  typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t                state_q, state_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           sh_q, sh_d;
  logic [ADDR_WIDTH:0]   hdr_q, hdr_d, cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d, word;
  logic                  acc, last;
`ifdef BOOT_CHECKSUM_EN
  assign busy_o = state_q inside {HDR, LOAD, CHK};
`else
  assign busy_o = state_q inside {HDR, LOAD};
`endif
  assign byte_ready_o  = busy_o;
  assign done_o        = state_q == DONE;
  assign error_o       = state_q == ERR;
  assign core_reset_no = done_o;
  assign imem_we_o     = we_q;
  assign imem_addr_o   = addr_q;
  assign imem_wdata_o  = wdata_q;
  assign word_count_o  = cnt_q;
  assign acc  = byte_valid_i && byte_ready_o;
  assign last = acc && bidx_q == 2'd3;
  assign word = {byte_data_i, sh_q};
  always_comb begin
    state_d = state_q;
    bidx_d  = acc ? bidx_q + 2'd1 : bidx_q;
    sh_d    = acc ? {byte_data_i, sh_q[23:8]} : sh_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: if (start_i) begin
        state_d = HDR;
        cnt_d   = '0;
        bidx_d  = '0;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      HDR: if (last) begin
        hdr_d   = word[ADDR_WIDTH:0];
        state_d = word == '0 ? FIN : word > MAX_WORDS ? ERR : LOAD;
      end
      LOAD: if (last) begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_WIDTH-1:0];
        wdata_d = word;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_d == hdr_q ? FIN : LOAD;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = sum_q + word;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: if (last) state_d = word == sum_q ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      bidx_q  <= '0;
      sh_q    <= '0;
      hdr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven image loads with a write scoreboard, plus reset-abort and checksum sequences.
module tb_imem_boot_loader;
  localparam int AW = 8;
  logic          clk_i = 0, reset_i = 0, start_i = 0, byte_valid_i = 0;
  logic [7:0]    byte_data_i = 0;
  logic          byte_ready_o, imem_we_o, core_reset_no, busy_o, done_o, error_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic [AW:0]   word_count_o;
  int checks = 0, errors = 0;
  bit noisy = 0;
  logic [AW+31:0] sb[$];
  typedef struct { int n; bit gaps; bit fixed; bit done; bit err; int cnt; } vec_t;
  vec_t tbl[6];

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o), .core_reset_no(core_reset_no),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .word_count_o(word_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) if (imem_we_o) begin
    if (sb.size() == 0) chk("unexpected_write", {imem_addr_o, imem_wdata_o}, '1);
    else chk("write_addr_data", {imem_addr_o, imem_wdata_o}, sb.pop_front());
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk_i);
    byte_valid_i = 1;
    byte_data_i  = b;
    start_i      = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!byte_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (t == 20) chk("ready_timeout", 0, 1);
    @(negedge clk_i);
    byte_valid_i = 0;
    start_i      = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic do_start();
    start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    chk("busy_after_start", {busy_o, byte_ready_o, core_reset_no, done_o, error_o}, 5'b11000);
  endtask

  task automatic run_image(input vec_t v);
    logic [31:0] w, sum = 0;
    do_start();
    send_word(v.n, v.gaps);
    if (!v.err) for (int i = 0; i < v.n; i++) begin
      w = v.fixed ? (i == 0 ? 32'h00500093 : 32'h00A00113) : $urandom;
      sb.push_back({i[AW-1:0], w});
      sum += w;
      noisy = v.gaps;
      send_word(w, v.gaps);
      noisy = 0;
    end
`ifdef BOOT_CHECKSUM_EN
    if (!v.err) send_word(sum, v.gaps);
`endif
    chk($sformatf("end_state_n%0d", v.n), {done_o, error_o, core_reset_no, busy_o}, {v.done, v.err, v.done, 1'b0});
    chk($sformatf("word_count_n%0d", v.n), word_count_o, v.cnt);
    repeat (3) @(negedge clk_i);
    chk("held_state", {done_o, error_o, core_reset_no}, {v.done, v.err, v.done});
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w0;
    tbl[0] = '{n: 2,   gaps: 0, fixed: 1, done: 1, err: 0, cnt: 2};
    tbl[1] = '{n: 0,   gaps: 0, fixed: 0, done: 1, err: 0, cnt: 0};
    tbl[2] = '{n: 257, gaps: 0, fixed: 0, done: 0, err: 1, cnt: 0};
    tbl[3] = '{n: 3,   gaps: 1, fixed: 0, done: 1, err: 0, cnt: 3};
    tbl[4] = '{n: 1,   gaps: 0, fixed: 0, done: 1, err: 0, cnt: 1};
    tbl[5] = '{n: 256, gaps: 0, fixed: 0, done: 1, err: 0, cnt: 256};
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", {byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_no,
        busy_o, done_o, error_o, word_count_o}, 0);
    reset_i = 1;
    @(negedge clk_i);
    chk("idle_after_reset", {busy_o, done_o, error_o, core_reset_no}, 0);
    for (int k = 0; k < 6; k++) run_image(tbl[k]);
    do_start();
    send_word(2, 0);
    w0 = 32'hDEADBEEF;
    sb.push_back({8'd0, w0});
    send_word(w0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset_i = 0;
    @(negedge clk_i);
    chk("abort_reset_outputs", {byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_no,
        busy_o, done_o, error_o, word_count_o}, 0);
    reset_i = 1;
    @(negedge clk_i);
    run_image(tbl[4]);
`ifdef BOOT_CHECKSUM_EN
    for (int t = 3; t <= 4; t++) begin
      do_start();
      send_word(2, 0);
      sb.push_back({8'd0, 32'h1});
      sb.push_back({8'd1, 32'h2});
      send_word(1, 0);
      send_word(2, 0);
      send_word(t, 0);
      chk($sformatf("checksum_%0d", t), {done_o, error_o, core_reset_no}, t == 3 ? 3'b101 : 3'b010);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
